// File: rtl/pipe_pkg.sv
// Purpose: shared types and constants for the elastic pipeline-stage registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   stage_state_t   occupancy state of one elastic stage (EMPTY / FULL / SKID)
//   CTRL_W_DEFAULT  control-word width shared by every stage and the control unit
//   CTRL_NOP        all-zero control word used as the bubble when no entry is valid
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entry held
        FULL  = 2'd1,   // main slot valid, skid slot empty
        SKID  = 2'd2    // both slots valid, upstream is being held off
    } stage_state_t;

    localparam int CTRL_W_DEFAULT = 21;

    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = '0;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// Purpose: one storage entry (valid + control word + payload) of an elastic stage.
// Latency: load/clear take effect on the next rising clk edge.
// Backpressure: none; the owning stage decides when to load or clear.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   load              capture in_data/in_ctrl and mark the entry valid
//   clear             invalidate the entry; ctrl becomes NOP, data zeroed only if CLR_DATA
//   in_data, in_ctrl  value to capture on load
//   valid, data, ctrl stored entry; ctrl is NOP whenever valid is 0
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = CTRL_W_DEFAULT,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clear wins over load so a squash can never be overridden by a
    // same-cycle capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
            // With CLR_DATA=0 the payload register is left alone so that an
            // emptied stage does not toggle its wide data bus.
            if (CLR_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end
    end

endmodule : pipe_slot

// File: rtl/pipe_stage_elastic.sv
// Purpose: elastic valid/ready pipeline-stage register with 2-entry skid and per-stage flush.
// Latency: 1 cycle from accept to out_valid; sustains 1 entry/cycle.
// Backpressure: in_ready is registered; the skid slot absorbs the one in-flight entry after out_ready drops.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      squash everything held; the in_valid entry of that cycle is dropped
//   in_valid/in_ready          upstream handshake (in_ready is a pure flop output)
//   in_data/in_ctrl            upstream payload and control word
//   out_valid/out_ready        downstream handshake
//   out_data/out_ctrl          registered payload and control; out_ctrl is NOP while out_valid=0
//   stall_cnt/flush_cnt        only when PIPE_STAGE_STATS_EN is defined: saturating counters of
//                              stalled cycles and of flushes that squashed at least one entry
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = CTRL_W_DEFAULT,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("pipe_stage_elastic: DATA_W, CTRL_W and CNT_W must all be >= 1");
    end

    stage_state_t state;
    stage_state_t state_nxt;

    logic accept;
    logic drain;

    logic main_load;
    logic main_from_skid;
    logic main_clear;
    logic skid_load;
    logic skid_clear;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic [DATA_W-1:0] main_in_data;
    logic [CTRL_W-1:0] main_in_ctrl;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // The main slot is the output register; the skid slot only ever feeds it.
    assign main_in_data = main_from_skid ? skid_data : in_data;
    assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    // ------------------------------------------------------------------
    // State register and registered in_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            // in_ready is decoded from the next state so it is available as a
            // flop output with no path back from in_valid or out_ready.
            in_ready <= (state_nxt != SKID);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and slot control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            state_nxt  = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        // Downstream stalled while upstream still had one in flight.
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end else if (drain) begin
                        main_clear = 1'b1;
                        state_nxt  = EMPTY;
                    end
                end
                SKID: begin
                    // skid_valid is always set here; gating on it keeps a
                    // corrupted state from promoting a stale entry.
                    if (drain && skid_valid) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_nxt      = FULL;
                    end
                end
                default: begin
                    state_nxt  = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (main_clear),
        .in_data (main_in_data),
        .in_ctrl (main_in_ctrl),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

`ifdef PIPE_STAGE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics; a flush squashes entries but keeps the history.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (main_valid || skid_valid) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule : pipe_stage_elastic

// File: tb/tb_pipe_stage_elastic.sv
// Purpose: self-checking bench for pipe_stage_elastic (CLR_DATA=1 and CLR_DATA=0 instances).
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: out_ready driven directly (directed and random patterns).
module tb_pipe_stage_elastic;

    localparam int DW  = 64;
    localparam int CW  = 21;
    localparam int CNW = 4;
    localparam int CNT_MAX = (1 << CNW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          in_ready,  in_ready_nc;
    logic          out_valid, out_valid_nc;
    logic [DW-1:0] out_data,  out_data_nc;
    logic [CW-1:0] out_ctrl,  out_ctrl_nc;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNW-1:0] stall_cnt, flush_cnt, stall_cnt_nc, flush_cnt_nc;
`endif

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA(1'b1), .CNT_W(CNW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA(1'b0), .CNT_W(CNW)) dut_nc (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_nc), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_nc), .out_ready(out_ready), .out_data(out_data_nc), .out_ctrl(out_ctrl_nc)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt_nc), .flush_cnt(flush_cnt_nc)
`endif
    );

    // Reference model: the stage is a FIFO of capacity 2 whose head is the output.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_head;   // last payload presented at the head (held when CLR_DATA=0)
    int            m_stall;
    int            m_flush;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
        logic [DW-1:0] e_d_nc;
        if (q.size() > 0) begin
            e_d    = q[0].d;
            e_c    = q[0].c;
            e_d_nc = q[0].d;
        end else begin
            e_d    = '0;
            e_c    = '0;
            e_d_nc = last_head;
        end
        check_eq("out_valid",    64'(out_valid),    64'(q.size() > 0));
        check_eq("in_ready",     64'(in_ready),     64'(q.size() < 2));
        check_eq("out_ctrl",     64'(out_ctrl),     64'(e_c));
        check_eq("out_data",     64'(out_data),     64'(e_d));
        check_eq("nc_out_valid", 64'(out_valid_nc), 64'(q.size() > 0));
        check_eq("nc_in_ready",  64'(in_ready_nc),  64'(q.size() < 2));
        check_eq("nc_out_ctrl",  64'(out_ctrl_nc),  64'(e_c));
        check_eq("nc_out_data",  64'(out_data_nc),  64'(e_d_nc));
`ifdef PIPE_STAGE_STATS_EN
        check_eq("stall_cnt",    64'(stall_cnt),    64'(m_stall));
        check_eq("flush_cnt",    64'(flush_cnt),    64'(m_flush));
        check_eq("nc_stall_cnt", 64'(stall_cnt_nc), 64'(m_stall));
        check_eq("nc_flush_cnt", 64'(flush_cnt_nc), 64'(m_flush));
`endif
    endtask

    // Advance the model by one clock using the inputs applied for that clock.
    task automatic model_update();
        bit do_drain;
        bit do_accept;
        if (reset) begin
            q.delete();
            last_head = '0;
            m_stall   = 0;
            m_flush   = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (flush) begin
                if (q.size() > 0 && m_flush < CNT_MAX) m_flush++;
                q.delete();
            end else begin
                do_drain  = (q.size() > 0) && out_ready;
                do_accept = in_valid && (q.size() < 2);
                if (do_drain) void'(q.pop_front());
                if (do_accept) q.push_back('{d: in_data, c: in_ctrl});
            end
            if (q.size() > 0) last_head = q[0].d;
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        @(negedge clk);
        check_outputs();
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        @(posedge clk);
        model_update();
    endtask

    function automatic logic [CW-1:0] ctl_of(input logic [DW-1:0] d);
        logic [CW-1:0] r;
        r = CW'(d) ^ 21'h15A5A5;
        return r;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        q.delete(); last_head = '0; m_stall = 0; m_flush = 0;

        // Reset state, then a stream of 1..8 at full rate.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, DW'(i), ctl_of(DW'(i)), 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // FULL with 0xA, stall, push 0xB -> SKID; then release.
        step(1'b0, 1'b0, 1'b1, 64'hA, ctl_of(64'hA), 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hB, ctl_of(64'hB), 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hD, ctl_of(64'hD), 1'b0);   // refused: in_ready low
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // SKID(0xA,0xB) then flush while offering 0xC.
        step(1'b0, 1'b0, 1'b1, 64'hA, ctl_of(64'hA), 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hB, ctl_of(64'hB), 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'hC, ctl_of(64'hC), 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Stall saturation: one entry held for 20 cycles.
        step(1'b0, 1'b0, 1'b1, 64'h5, ctl_of(64'h5), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Reset mid-stream while in SKID.
        step(1'b0, 1'b0, 1'b1, 64'h11, ctl_of(64'h11), 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'h22, ctl_of(64'h22), 1'b0);
        step(1'b1, 1'b0, 1'b1, 64'h33, ctl_of(64'h33), 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] d;
            logic          iv, ordy, fl, rst;
            d    = {$urandom(), $urandom()};
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 5);
            rst  = ($urandom_range(0, 199) == 0);
            step(rst, fl, iv, d, ctl_of(d) | CW'(1), ordy);
        end

        @(negedge clk);
        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_elastic
